switch_sampler: RTL
===================

// Module: switch_sampler
// PURPOSE
//  Upstream input stage for the ZedBoard adder labs: brings raw async SWITCH pins into the clock domain.
//  Debounces them and offers each newly settled switch word to the downstream adder through a valid/ready handshake.
//  out_data[3:0] feeds operand A and out_data[7:4] feeds operand B; the adder result drives LED.
// PARAMETERS
//  WIDTH            8          switch word width (even; >=2)
//  DEBOUNCE_CYCLES  1000000    cycles a new value must hold before acceptance (10 ms @100 MHz; >=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  localparam, debounce counter width
// PORTS
//  CLOCK      in   1      single system clock, all state on rising edge
//  RESET_N    in   1      asynchronous, active-low reset
//  SWITCH     in   WIDTH  raw switch pins, asynchronous, may bounce
//  out_valid  out  1      out_data holds a new settled word
//  out_ready  in   1      downstream accepts; transfer = out_valid & out_ready at rising edge
//  out_data   out  WIDTH  settled switch word ([WIDTH/2-1:0]=A, [WIDTH-1:WIDTH/2]=B)
// BEHAVIOUR
//  Reset (async assert, sync deassert by board logic): sync regs, cand, stable, cnt, out_data = 0; out_valid = 0; FSM = IDLE.
//  Sync: 2-FF synchronizer per bit -> sync2. No other logic samples SWITCH.
//  Debounce: if sync2 != cand -> cand<=sync2, cnt<=0.
//   Else if cand != stable: cnt<=cnt+1; when cnt==DEBOUNCE_CYCLES-1 -> stable<=cand, cnt<=0.
//   Else cnt holds 0.
//   Any change of sync2 restarts the count, so only values held for DEBOUNCE_CYCLES consecutive cycles are accepted.
//  Latency: SWITCH settled before edge k -> stable updates at edge k+DEBOUNCE_CYCLES+2.
//   out_valid rises at edge k+DEBOUNCE_CYCLES+3 when FSM is IDLE.
//  FSM (out_data doubles as "last offered/accepted" word):
//   IDLE (out_valid=0): if stable != out_data -> out_data<=stable, go HOLD.
//   HOLD (out_valid=1): out_data stays frozen while !out_ready.
//    On transfer: if stable != out_data -> out_data<=stable, stay HOLD (back-to-back offer); else go IDLE.
//  Latest-wins: settled values that occur while HOLD is backpressured are overwritten in stable; only the newest is offered.
//  A settled value equal to the last accepted word produces no offer.
//  out_valid never drops without a transfer, except on reset.
//  Reset mid-HOLD: out_valid=0 and out_data=0 immediately (async), pending word lost.
//  Simultaneous sync2 change and debounce terminal count: the change wins (cand reloads, stable unchanged).
// CONFIGURATION
//  SWITCH_SAMPLER_CHANGE_COUNT_EN defined: extra port change_count out 8.
//   change_count increments on every out_valid&out_ready transfer, wraps 255->0, resets to 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package switch_pkg: DEFAULT_DEBOUNCE_CYCLES constant, typedef enum logic {S_IDLE,S_HOLD} sampler_state_t.
//  Sub-module switch_sync #(WIDTH): 2-FF synchronizer with async active-low reset to 0.
//  Debounce counter and FSM stay inline.
// TESTING (bench uses DEBOUNCE_CYCLES=4; SWITCH changes between edges)
//  1 RESET_N=0 with SWITCH=8'hFF -> out_valid=0, out_data=0 during reset; after release 0xFF is offered at edge 7.
//  2 SWITCH 00->8'h35 at k, out_ready=1 -> out_valid=1 only at edge k+7, one cycle, out_data=8'h35.
//  3 Toggle bit0 every 2 cycles for 20 cycles, then hold 8'h01 -> exactly one transfer, data 8'h01.
//  4 out_ready=0; SWITCH 0x11, 0x22, 0x33 each held 10 cycles -> out_data stays 0x11.
//     Raise out_ready -> 0x11 accepted, 0x33 offered next cycle, 0x22 never offered.
//  5 After 0x33 accepted, glitch to 0x44 for 3 cycles then back to 0x33 -> no out_valid.
//  6 Async RESET_N low mid-HOLD between edges -> out_valid, out_data go 0 without a clock edge.
//     With macro: change_count reaches 0 after 256 transfers.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared constants and types for the switch sampler input stage.
package switch_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

   typedef enum logic {S_IDLE, S_HOLD} sampler_state_t;

endpackage

// File: rtl/switch_sampler_if.sv
// Valid/ready channel carrying settled switch words to the downstream adder.
interface switch_sampler_if #(
   parameter int WIDTH = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/switch_sync.sv
// Two-flop synchronizer bringing raw switch pins into the clock domain.
module switch_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/switch_sampler.sv
// Synchronizes, debounces and offers settled switch words over valid/ready.
// Optional SWITCH_SAMPLER_CHANGE_COUNT_EN adds an 8-bit wrapping transfer counter.
module switch_sampler
   import switch_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] SWITCH,
   switch_sampler_if.master out_if
`ifdef SWITCH_SAMPLER_CHANGE_COUNT_EN
   ,
   output logic [7:0]       change_count
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] stable;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             xfer;
   sampler_state_t   state_q;
   sampler_state_t   state_d;

   switch_sync #(.WIDTH(WIDTH)) u_sync (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .d     (SWITCH),
      .q     (sync2)
   );

   // A change of sync2 always wins over a terminal count, restarting the hold window.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         cand   <= '0;
         stable <= '0;
         cnt    <= '0;
      end else if (sync2 != cand) begin
         cand <= sync2;
         cnt  <= '0;
      end else if (cand != stable) begin
         if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= cand;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // data_q is both the offered word and the last accepted one, so repeats are suppressed.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (stable != data_q) begin
               data_d  = stable;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (xfer) begin
               if (stable != data_q) begin
                  data_d = stable;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   assign out_if.out_valid = (state_q == S_HOLD);
   assign out_if.out_data  = data_q;
   assign xfer             = out_if.out_valid & out_if.out_ready;

`ifdef SWITCH_SAMPLER_CHANGE_COUNT_EN
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         change_count <= '0;
      end else if (xfer) begin
         change_count <= change_count + 8'd1;
      end
   end
`endif

endmodule
